stream_fifo_1clk_pkt: RTL and testbench

//  Single-clock valid/ready stream FIFO with a last-flag sideband and an optional packet mode.

---
 rtl/stream_fifo_1clk_pkt.sv | 119 +++++++++++
 tb/tb_stream_fifo_1clk_pkt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_1clk_pkt.sv
// Single-clock valid/ready stream FIFO carrying a last flag per word, with occupancy and packet
// counts, almost-full/empty flags and an optional store-and-forward packet mode.
module stream_fifo_1clk_pkt #(
  parameter int unsigned Width       = 8,
  parameter int unsigned Depth       = 100,
  parameter bit          PacketMode  = 1'b0,
  parameter int unsigned AlmostFull  = 96,
  parameter int unsigned AlmostEmpty = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [Width-1:0]           din_data,
  input  logic                       din_last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [Width-1:0]           dout_data,
  output logic                       dout_last,
  output logic [$clog2(Depth+1)-1:0] used,
  output logic [$clog2(Depth+1)-1:0] pkt_count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int unsigned     CntW     = $clog2(Depth + 1);
  localparam int unsigned     PtrW     = $clog2(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AlmostFull);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AlmostEmpty);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  // Each entry holds {last, data}.
  logic [Width:0]    mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   used_q, used_d;
  logic [CntW-1:0]   pkt_q, pkt_d;
  logic [Width:0]    rd_word;
  logic              full, empty;
  logic              wr_en, rd_en;
  logic              pkt_in, pkt_out;
  logic              out_avail;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (used_q == DepthCnt);
  assign empty   = (used_q == '0);
  assign rd_word = mem_q[rd_ptr_q];

  // Full FIFO is the deadlock escape for packets longer than the storage.
  assign out_avail = !empty && (!PacketMode || (pkt_q != '0) || full);

  // Held low while in reset even though the registered state already reads empty.
  assign din_ready = rst && !full;
  assign wr_en     = din_valid && din_ready;
  assign rd_en     = out_avail && dout_ready;
  assign pkt_in    = wr_en && din_last;
  assign pkt_out   = rd_en && rd_word[Width];

  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    used_d = used_q;
    unique case ({wr_en, rd_en})
      2'b10:   used_d = used_q + CntW'(1);
      2'b01:   used_d = used_q - CntW'(1);
      default: used_d = used_q;
    endcase

    pkt_d = pkt_q;
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_d = pkt_q + CntW'(1);
      2'b01:   pkt_d = pkt_q - CntW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage has no reset so it can map onto RAM; stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {din_last, din_data};
    end
  end

  always_comb begin
    dout_valid   = out_avail;
    dout_data    = out_avail ? rd_word[Width-1:0] : '0;
    dout_last    = out_avail ? rd_word[Width] : 1'b0;
    used         = used_q;
    pkt_count    = pkt_q;
    almost_full  = (used_q >= AfCnt);
    almost_empty = (used_q <= AeCnt);
  end

  a_used_bound : assert property (@(posedge clk) disable iff (!rst) used_q <= DepthCnt);
  a_pkt_bound  : assert property (@(posedge clk) disable iff (!rst) pkt_q <= used_q);
  a_out_stable : assert property (@(posedge clk) disable iff (!rst)
                                  dout_valid && !dout_ready |=>
                                  $stable({dout_valid, dout_last, dout_data}));

endmodule

// File: tb/tb_stream_fifo_1clk_pkt.sv
// Scoreboard bench for stream_fifo_1clk_pkt: three instances (default, Depth=5, packet mode
// Depth=8) driven by directed stimulus, checked by one monitor every cycle.
module tb_stream_fifo_1clk_pkt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv [3];
  logic       dl [3];
  logic       dr [3];
  logic [7:0] dd [3];
  logic       rdy[3];
  logic       ov [3];
  logic       ol [3];
  logic       af [3];
  logic       ae [3];
  logic [7:0] od [3];
  logic [6:0] u0, p0;
  logic [2:0] u1, p1;
  logic [3:0] u2, p2;

  logic [8:0] q0[$], q1[$], q2[$];
  int plast[3];
  int reads[3];
  int exp_reads[3];
  int n_checks = 0;
  int n_fail   = 0;
  int timeouts = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  stream_fifo_1clk_pkt #(.Width(8), .Depth(100), .PacketMode(1'b0), .AlmostFull(96),
                         .AlmostEmpty(4)) dut0 (
    .clk(clk), .rst(rst), .din_valid(dv[0]), .din_ready(rdy[0]), .din_data(dd[0]),
    .din_last(dl[0]), .dout_valid(ov[0]), .dout_ready(dr[0]), .dout_data(od[0]),
    .dout_last(ol[0]), .used(u0), .pkt_count(p0), .almost_full(af[0]), .almost_empty(ae[0])
  );

  stream_fifo_1clk_pkt #(.Width(8), .Depth(5), .PacketMode(1'b0), .AlmostFull(4),
                         .AlmostEmpty(1)) dut1 (
    .clk(clk), .rst(rst), .din_valid(dv[1]), .din_ready(rdy[1]), .din_data(dd[1]),
    .din_last(dl[1]), .dout_valid(ov[1]), .dout_ready(dr[1]), .dout_data(od[1]),
    .dout_last(ol[1]), .used(u1), .pkt_count(p1), .almost_full(af[1]), .almost_empty(ae[1])
  );

  stream_fifo_1clk_pkt #(.Width(8), .Depth(8), .PacketMode(1'b1), .AlmostFull(6),
                         .AlmostEmpty(2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(dv[2]), .din_ready(rdy[2]), .din_data(dd[2]),
    .din_last(dl[2]), .dout_valid(ov[2]), .dout_ready(dr[2]), .dout_data(od[2]),
    .dout_last(ol[2]), .used(u2), .pkt_count(p2), .almost_full(af[2]), .almost_empty(ae[2])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 100 : (k == 1) ? 5 : 8;
  endfunction
  function automatic int pm(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int afv(input int k);
    return (k == 0) ? 96 : (k == 1) ? 4 : 6;
  endfunction
  function automatic int aev(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 2;
  endfunction

  function automatic void chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endfunction

  // Monitor: compares all three instances against the queue model on every falling edge.
  initial begin
    int uv, pv, sz, vexp;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        uv = (k == 0) ? int'(u0) : (k == 1) ? int'(u1) : int'(u2);
        pv = (k == 0) ? int'(p0) : (k == 1) ? int'(p1) : int'(p2);
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (!rst) begin
          if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
          plast[k] = 0;
          chk("rst_used", k, uv, 0);
          chk("rst_pkt_count", k, pv, 0);
          chk("rst_din_ready", k, int'(rdy[k]), 0);
          chk("rst_dout_valid", k, int'(ov[k]), 0);
          chk("rst_dout_word", k, int'({ol[k], od[k]}), 0);
          chk("rst_almost_full", k, int'(af[k]), 0);
          chk("rst_almost_empty", k, int'(ae[k]), 1);
        end else begin
          vexp = int'(sz != 0 && (pm(k) == 0 || plast[k] != 0 || sz == dep(k)));
          chk("used", k, uv, sz);
          chk("pkt_count", k, pv, plast[k]);
          chk("din_ready", k, int'(rdy[k]), int'(sz != dep(k)));
          chk("almost_full", k, int'(af[k]), int'(sz >= afv(k)));
          chk("almost_empty", k, int'(ae[k]), int'(sz <= aev(k)));
          chk("dout_valid", k, int'(ov[k]), vexp);
          if (ov[k] && dr[k]) begin
            if (sz == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL underflow[dut%0d] at %0t: got word %0h, expected none", k, $time,
                       {ol[k], od[k]});
            end else begin
              if (k == 0) e = q0.pop_front(); else if (k == 1) e = q1.pop_front();
              else e = q2.pop_front();
              chk("dout_word", k, int'({ol[k], od[k]}), int'(e));
              reads[k]++;
              if (e[8]) plast[k]--;
            end
          end
          if (dv[k] && rdy[k]) begin
            if (k == 0) q0.push_back({dl[k], dd[k]}); else if (k == 1) q1.push_back({dl[k], dd[k]});
            else q2.push_back({dl[k], dd[k]});
            if (dl[k]) plast[k]++;
          end
        end
      end
      if (end_req && !end_done) begin
        for (int k = 0; k < 3; k++) begin
          sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
          chk("total_reads", k, reads[k], exp_reads[k]);
          chk("words_left", k, sz, 0);
        end
        chk("timeouts", 0, timeouts, 0);
        end_done = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int k, input int n, input int max_cyc);
    int c;
    c = 0;
    while (reads[k] < n && c < max_cyc) begin
      cyc();
      c++;
    end
    if (reads[k] < n) begin
      timeouts++;
      $display("FAIL wait_reads[dut%0d]: got %0d reads, expected %0d", k, reads[k], n);
    end
  endtask

  initial begin
    int w;
    logic acc;
    exp_reads[0] = 204;
    exp_reads[1] = 23;
    exp_reads[2] = 13;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 1'b0; dl[k] = 1'b0; dr[k] = 1'b0; dd[k] = 8'h00;
      plast[k] = 0; reads[k] = 0;
    end
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    // Fill dut0 to 100 words, last on every tenth, then offer a 101st word.
    for (int i = 0; i < 100; i++) begin
      dv[0] = 1'b1; dd[0] = 8'(i); dl[0] = (i % 10 == 9);
      cyc();
    end
    dd[0] = 8'hAA; dl[0] = 1'b0;
    repeat (3) cyc();

    // Drain while writing every cycle: the first offer is refused, later ones accepted.
    dr[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dd[0] = 8'(100 + i); dl[0] = ((100 + i) % 10 == 9);
      cyc();
    end
    dv[0] = 1'b0;
    wait_reads(0, 199, 150);
    dr[0] = 1'b0;

    // Depth-5 instance with random valid/ready.
    w = 0;
    for (int c = 0; c < 400 && (w < 23 || reads[1] < 23); c++) begin
      dv[1] = (w < 23) && ($urandom_range(0, 1) == 1);
      dd[1] = 8'(8'h30 + w);
      dl[1] = (w % 4 == 3);
      dr[1] = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = dv[1] && rdy[1];
      cyc();
      if (acc) w++;
    end
    dv[1] = 1'b0;
    dr[1] = 1'b1;
    wait_reads(1, 23, 40);

    // Packet mode: A, B, gap, C(last) -- nothing may come out before C is stored.
    dr[2] = 1'b1;
    dv[2] = 1'b1; dd[2] = 8'h0A; dl[2] = 1'b0; cyc();
    dd[2] = 8'h0B; cyc();
    dv[2] = 1'b0; repeat (3) cyc();
    dv[2] = 1'b1; dd[2] = 8'h0C; dl[2] = 1'b1; cyc();
    dv[2] = 1'b0; dl[2] = 1'b0;
    wait_reads(2, 3, 20);

    // Oversize packet: 10 words into 8 slots, released by the full-FIFO escape.
    dr[2] = 1'b0;
    w = 0;
    for (int c = 0; c < 80 && reads[2] < 13; c++) begin
      dv[2] = (w < 10);
      dd[2] = 8'(8'h50 + w);
      dl[2] = (w == 9);
      dr[2] = (w >= 8);
      @(negedge clk);
      acc = dv[2] && rdy[2];
      cyc();
      if (acc) w++;
    end
    dv[2] = 1'b0;
    wait_reads(2, 13, 20);

    // Reset mid-stream with 37 words and 2 complete packets held, then fresh data.
    dr[0] = 1'b0;
    for (int i = 0; i < 37; i++) begin
      dv[0] = 1'b1; dd[0] = 8'(8'h80 + i); dl[0] = (i == 9 || i == 19);
      cyc();
    end
    dv[0] = 1'b0; dl[0] = 1'b0;
    cyc();
    #2 rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    dr[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dv[0] = 1'b1; dd[0] = 8'(8'hE0 + i); dl[0] = (i == 4);
      cyc();
    end
    dv[0] = 1'b0; dl[0] = 1'b0;
    wait_reads(0, 204, 20);

    end_req = 1'b1;
    repeat (3) cyc();
    if (!end_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL end_check: got not done, expected done");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
